// File: rtl/interface_spimaster.sv
// Frame-based mode-0 SPI master: each accepted start shifts one BUFFER_SIZE-bit
// frame out on MOSI (MSB first), captures the reply and classifies its header.
module interface_spimaster #(
  parameter int          BUFFER_SIZE = 272,
  parameter int          CLK_DIV     = 4,
  parameter logic [31:0] HDR_DATA    = 32'h61746164,
  parameter logic [31:0] HDR_ESTOP   = 32'h70747365
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [BUFFER_SIZE-1:0] tx_data,
  output logic                   busy,
  output logic                   done,
  output logic [BUFFER_SIZE-1:0] rx_data,
  output logic                   rx_valid,
  output logic                   rx_estop,
  output logic [7:0]             err_count,
  output logic                   SPI_SCK,
  output logic                   SPI_SSEL,
  output logic                   SPI_MOSI,
  input  logic                   SPI_MISO
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CNT_W = $clog2(BUFFER_SIZE);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(BUFFER_SIZE - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEAD,
    ST_HIGH,
    ST_LOW,
    ST_TRAIL,
    ST_GAP
  } state_t;

  state_t                 state_reg, state_next;
  logic [DIV_W-1:0]       div_reg, div_next;
  logic [CNT_W-1:0]       bit_cnt_reg, bit_cnt_next;
  logic [BUFFER_SIZE-1:0] shift_reg, shift_next;
  logic [BUFFER_SIZE-1:0] rx_data_reg, rx_data_next;
  logic                   sck_reg, sck_next;
  logic                   ssel_reg, ssel_next;
  logic                   mosi_reg, mosi_next;
  logic                   busy_reg, busy_next;
  logic                   done_reg, done_next;
  logic                   rx_valid_reg, rx_valid_next;
  logic                   rx_estop_reg, rx_estop_next;
  logic [7:0]             err_reg, err_next;
  logic [1:0]             miso_sync_reg;

  logic                   miso_s;
  logic                   phase_end;
  logic [31:0]            hdr;
  logic                   hdr_is_data;
  logic                   hdr_is_estop;

  assign miso_s       = miso_sync_reg[1];
  assign phase_end    = (div_reg == DIV_LAST);
  assign hdr          = shift_reg[BUFFER_SIZE-1 -: 32];
  assign hdr_is_data  = (hdr == HDR_DATA);
  assign hdr_is_estop = (hdr == HDR_ESTOP);

  always_ff @(posedge clk) begin
    if (rst) begin
      miso_sync_reg <= 2'b00;
    end else begin
      miso_sync_reg <= {miso_sync_reg[0], SPI_MISO};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      div_reg      <= '0;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
      rx_data_reg  <= '0;
      sck_reg      <= 1'b0;
      ssel_reg     <= 1'b1;
      mosi_reg     <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      rx_valid_reg <= 1'b0;
      rx_estop_reg <= 1'b0;
      err_reg      <= 8'd0;
    end else begin
      state_reg    <= state_next;
      div_reg      <= div_next;
      bit_cnt_reg  <= bit_cnt_next;
      shift_reg    <= shift_next;
      rx_data_reg  <= rx_data_next;
      sck_reg      <= sck_next;
      ssel_reg     <= ssel_next;
      mosi_reg     <= mosi_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
      rx_valid_reg <= rx_valid_next;
      rx_estop_reg <= rx_estop_next;
      err_reg      <= err_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    div_next      = div_reg;
    bit_cnt_next  = bit_cnt_reg;
    shift_next    = shift_reg;
    rx_data_next  = rx_data_reg;
    sck_next      = sck_reg;
    ssel_next     = ssel_reg;
    mosi_next     = mosi_reg;
    busy_next     = busy_reg;
    done_next     = 1'b0;
    rx_valid_next = rx_valid_reg;
    rx_estop_next = rx_estop_reg;
    err_next      = err_reg;

    if (state_reg != ST_IDLE) begin
      div_next = phase_end ? '0 : div_reg + DIV_W'(1);
    end

    case (state_reg)
      ST_IDLE: begin
        div_next = '0;
        if (start) begin
          shift_next   = tx_data;
          bit_cnt_next = '0;
          ssel_next    = 1'b0;
          mosi_next    = tx_data[BUFFER_SIZE-1];
          busy_next    = 1'b1;
          state_next   = ST_LEAD;
        end
      end

      ST_LEAD: begin
        if (phase_end) begin
          sck_next   = 1'b1;
          state_next = ST_HIGH;
        end
      end

      // Capture at the end of the high phase: by then the 2-FF synchroniser
      // output holds the MISO level that was present at the rising edge.
      ST_HIGH: begin
        if (phase_end) begin
          sck_next   = 1'b0;
          shift_next = {shift_reg[BUFFER_SIZE-2:0], miso_s};
          if (bit_cnt_reg == BIT_LAST) begin
            state_next = ST_TRAIL;
          end else begin
            bit_cnt_next = bit_cnt_reg + CNT_W'(1);
            mosi_next    = shift_reg[BUFFER_SIZE-2];
            state_next   = ST_LOW;
          end
        end
      end

      ST_LOW: begin
        if (phase_end) begin
          sck_next   = 1'b1;
          state_next = ST_HIGH;
        end
      end

      ST_TRAIL: begin
        if (phase_end) begin
          ssel_next     = 1'b1;
          rx_data_next  = shift_reg;
          rx_valid_next = hdr_is_data;
          rx_estop_next = hdr_is_estop;
          if (!hdr_is_data && !hdr_is_estop && (err_reg != 8'hFF)) begin
            err_next = err_reg + 8'd1;
          end
          done_next  = 1'b1;
          state_next = ST_GAP;
        end
      end

      ST_GAP: begin
        if (phase_end) begin
          busy_next  = 1'b0;
          state_next = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign busy      = busy_reg;
  assign done      = done_reg;
  assign rx_data   = rx_data_reg;
  assign rx_valid  = rx_valid_reg;
  assign rx_estop  = rx_estop_reg;
  assign err_count = err_reg;
  assign SPI_SCK   = sck_reg;
  assign SPI_SSEL  = ssel_reg;
  assign SPI_MOSI  = mosi_reg;

endmodule

// File: tb/tb_interface_spimaster.sv
// Bench for interface_spimaster: behavioural mode-0 slave, table vectors,
// randomized frames against a header-classification model, and corner sequences.
module tb_interface_spimaster;

  localparam int          BS        = 40;
  localparam int          CD        = 2;
  localparam logic [31:0] HDR_DATA  = 32'h61746164;
  localparam logic [31:0] HDR_ESTOP = 32'h70747365;
  localparam int          FRAME_CYC = (2*BS+1)*CD;
  localparam int          TMO       = 4*FRAME_CYC;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [BS-1:0] tx_data = '0;
  logic          busy, done, rx_valid, rx_estop;
  logic [BS-1:0] rx_data;
  logic [7:0]    err_count;
  logic          spi_sck, spi_ssel, spi_mosi;
  logic          spi_miso = 1'b0;

  interface_spimaster #(
    .BUFFER_SIZE(BS), .CLK_DIV(CD), .HDR_DATA(HDR_DATA), .HDR_ESTOP(HDR_ESTOP)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .tx_data(tx_data),
    .busy(busy), .done(done), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_estop(rx_estop), .err_count(err_count),
    .SPI_SCK(spi_sck), .SPI_SSEL(spi_ssel), .SPI_MOSI(spi_mosi), .SPI_MISO(spi_miso)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int frame_no = 0;

  task automatic check(input string tag, input string name,
                       input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %0h, expected %0h", tag, name, act, exp);
    end
  endtask

  // Mode-0 slave: presents MSB on select, samples MOSI on SCK rise, shifts on SCK fall.
  logic [BS-1:0] slv_reply = '0;
  logic [BS-1:0] slv_out = '0;
  logic [BS-1:0] slv_in = '0;
  logic [BS-1:0] slv_last_rx = '0;
  int            slv_bits = 0;
  int            slv_last_bits = 0;
  int            sck_rises = 0;
  logic          prev_ssel = 1'b1;
  logic          prev_sck = 1'b0;

  always @(spi_ssel or spi_sck) begin
    if (prev_ssel === 1'b1 && spi_ssel === 1'b0) begin
      slv_out  = slv_reply;
      slv_in   = '0;
      slv_bits = 0;
      spi_miso = slv_out[BS-1];
    end else if (prev_ssel === 1'b0 && spi_ssel === 1'b1) begin
      slv_last_rx   = slv_in;
      slv_last_bits = slv_bits;
    end
    if (prev_sck === 1'b0 && spi_sck === 1'b1) begin
      sck_rises++;
      if (spi_ssel === 1'b0) begin
        slv_in = {slv_in[BS-2:0], spi_mosi};
        slv_bits++;
      end
    end else if (prev_sck === 1'b1 && spi_sck === 1'b0 && spi_ssel === 1'b0) begin
      slv_out  = slv_out << 1;
      spi_miso = slv_out[BS-1];
    end
    prev_ssel = spi_ssel;
    prev_sck  = spi_sck;
  end

  // Cycle-level timing monitor, sampled on the inactive edge.
  int   cyc = 0, accept_cyc = 0, done_cyc = 0, prev_done_cyc = 0, done_cnt = 0;
  int   low_run = 0, high_run = 0, last_low = 0, last_high = 0;
  logic busy_prev = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (busy === 1'b1 && busy_prev !== 1'b1) accept_cyc = cyc;
    busy_prev = busy;
    if (done === 1'b1) begin
      prev_done_cyc = done_cyc;
      done_cyc      = cyc;
      done_cnt++;
    end
    if (spi_ssel === 1'b0) begin
      if (high_run != 0) last_high = high_run;
      high_run = 0;
      low_run++;
    end else begin
      if (low_run != 0) last_low = low_run;
      low_run = 0;
      high_run++;
    end
  end

  typedef struct {
    logic [BS-1:0] tx;
    logic [BS-1:0] reply;
    logic          exp_valid;
    logic          exp_estop;
    logic [7:0]    exp_err;
  } vec_t;

  vec_t vecs[7];
  int   exp_err = 0;
  int   sck_snap = 0;

  task automatic wait_idle(input string tag);
    bit ok = 0;
    for (int i = 0; i < TMO; i++) begin
      @(negedge clk); #1;
      if (busy === 1'b0) begin ok = 1; break; end
    end
    if (!ok) begin
      n_checks++; n_fail++;
      $display("FAIL %s.idle_timeout: busy still %b after %0d cycles, expected 0", tag, busy, TMO);
    end
  endtask

  task automatic wait_done(input string tag);
    bit ok = 0;
    for (int i = 0; i < TMO; i++) begin
      @(negedge clk); #1;
      if (done === 1'b1) begin ok = 1; break; end
    end
    if (!ok) begin
      n_checks++; n_fail++;
      $display("FAIL %s.done_timeout: done still %b after %0d cycles, expected 1", tag, done, TMO);
    end
  endtask

  task automatic run_frame(input string tag, input logic [BS-1:0] tx, input logic [BS-1:0] reply);
    wait_idle(tag);
    slv_reply = reply;
    tx_data   = tx;
    sck_snap  = sck_rises;
    start     = 1'b1;
    @(negedge clk); #1;
    start   = 1'b0;
    tx_data = ~tx;
    wait_done(tag);
    frame_no++;
    $display("frame %0d [%s] tx=%h reply=%h rx_data=%h valid=%b estop=%b err=%0d",
             frame_no, tag, tx, reply, rx_data, rx_valid, rx_estop, err_count);
  endtask

  task automatic check_common(input string tag, input logic [BS-1:0] tx, input logic [BS-1:0] reply);
    check(tag, "slave_rx",   64'(slv_last_rx), 64'(tx));
    check(tag, "slave_bits", 64'(slv_last_bits), 64'(BS));
    check(tag, "sck_rises",  64'(sck_rises - sck_snap), 64'(BS));
    check(tag, "rx_data",    64'(rx_data), 64'(reply));
    check(tag, "done_lat",   64'(done_cyc - accept_cyc), 64'(FRAME_CYC));
    check(tag, "ssel_low",   64'(last_low), 64'(FRAME_CYC));
  endtask

  // Reference classification: header is the top 32 bits of the returned frame.
  task automatic check_model(input string tag, input logic [BS-1:0] reply);
    logic [31:0] h;
    logic        ev, ee;
    h  = reply[BS-1 -: 32];
    ev = (h == HDR_DATA);
    ee = (h == HDR_ESTOP);
    if (!ev && !ee) exp_err = (exp_err >= 255) ? 255 : exp_err + 1;
    check(tag, "rx_valid",  64'(rx_valid), 64'(ev));
    check(tag, "rx_estop",  64'(rx_estop), 64'(ee));
    check(tag, "err_count", 64'(err_count), 64'(exp_err));
  endtask

  logic [BS-1:0] tx_r, rep_r;
  int            dn_snap;

  initial begin
    vecs[0] = '{40'h0123456789, 40'h617461645A, 1'b1, 1'b0, 8'd0};
    vecs[1] = '{40'hFEDCBA9876, 40'h7074736500, 1'b0, 1'b1, 8'd0};
    vecs[2] = '{40'hAAAAAAAAAA, 40'hFFFFFFFFFF, 1'b0, 1'b0, 8'd1};
    vecs[3] = '{40'h5555555555, 40'h6174616500, 1'b0, 1'b0, 8'd2};
    vecs[4] = '{40'h8000000001, 40'h0000000000, 1'b0, 1'b0, 8'd3};
    vecs[5] = '{40'h61746164A5, 40'h7074736480, 1'b0, 1'b0, 8'd4};
    vecs[6] = '{40'hFFFFFFFFFF, 40'h61746164FF, 1'b1, 1'b0, 8'd4};

    // Reset values
    repeat (3) @(negedge clk);
    #1;
    check("reset", "ssel",      64'(spi_ssel), 64'd1);
    check("reset", "sck",       64'(spi_sck), 64'd0);
    check("reset", "mosi",      64'(spi_mosi), 64'd0);
    check("reset", "busy",      64'(busy), 64'd0);
    check("reset", "done",      64'(done), 64'd0);
    check("reset", "rx_data",   64'(rx_data), 64'd0);
    check("reset", "status",    64'({rx_valid, rx_estop}), 64'd0);
    check("reset", "err_count", 64'(err_count), 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Table vectors, expectations written out as constants
    for (int i = 0; i < 7; i++) begin
      run_frame("table", vecs[i].tx, vecs[i].reply);
      check_common("table", vecs[i].tx, vecs[i].reply);
      check("table", "rx_valid",  64'(rx_valid), 64'(vecs[i].exp_valid));
      check("table", "rx_estop",  64'(rx_estop), 64'(vecs[i].exp_estop));
      check("table", "err_count", 64'(err_count), 64'(vecs[i].exp_err));
    end
    exp_err = 4;

    // Slave echoes one frame late
    run_frame("echo_a", 40'h61746164A5, 40'h7074736511);
    check_common("echo_a", 40'h61746164A5, 40'h7074736511);
    check_model("echo_a", 40'h7074736511);
    tx_r = {$urandom, 8'($urandom)};
    rep_r = slv_last_rx;
    run_frame("echo_b", tx_r, rep_r);
    check("echo_b", "rx_data_echo", 64'(rx_data), 64'h61746164A5);
    check("echo_b", "rx_valid_echo", 64'(rx_valid), 64'd1);
    check_model("echo_b", rep_r);

    // Randomized frames
    for (int i = 0; i < 40; i++) begin
      tx_r = {$urandom, 8'($urandom)};
      case ($urandom_range(0, 3))
        0:       rep_r = {HDR_DATA, 8'($urandom)};
        1:       rep_r = {HDR_ESTOP, 8'($urandom)};
        default: rep_r = {$urandom, 8'($urandom)};
      endcase
      run_frame("random", tx_r, rep_r);
      check_common("random", tx_r, rep_r);
      check_model("random", rep_r);
    end

    // start pulsed while busy is ignored
    wait_idle("busy_start");
    dn_snap = done_cnt;
    tx_r = 40'h1122334455;
    slv_reply = {HDR_DATA, 8'h3C};
    tx_data = tx_r;
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    repeat (30) @(negedge clk);
    #1;
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    wait_done("busy_start");
    repeat (2*FRAME_CYC) @(negedge clk);
    #1;
    check("busy_start", "done_count", 64'(done_cnt - dn_snap), 64'd1);
    check("busy_start", "slave_rx",   64'(slv_last_rx), 64'(tx_r));
    check("busy_start", "ssel_idle",  64'(spi_ssel), 64'd1);
    check_model("busy_start", {HDR_DATA, 8'h3C});

    // start held high: back-to-back frames
    wait_idle("held");
    dn_snap = done_cnt;
    tx_r = 40'hC3C3C3C3C3;
    slv_reply = {HDR_DATA, 8'h01};
    tx_data = tx_r;
    start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_done("held");
      check_model("held", {HDR_DATA, 8'h01});
    end
    start = 1'b0;
    check("held", "ssel_gap",    64'(last_high), 64'd3);
    check("held", "done_period", 64'(done_cyc - prev_done_cyc), 64'(FRAME_CYC + CD + 1));
    check("held", "slave_rx",    64'(slv_last_rx), 64'(tx_r));
    repeat (2*FRAME_CYC) @(negedge clk);
    #1;
    check("held", "done_count", 64'(done_cnt - dn_snap), 64'd3);

    // Error counter saturation
    for (int i = 0; i < 300; i++) begin
      tx_r = {$urandom, 8'($urandom)};
      rep_r = {32'hFFFFFFFF, 8'($urandom)};
      run_frame("saturate", tx_r, rep_r);
      check_model("saturate", rep_r);
    end
    check("saturate", "err_255", 64'(err_count), 64'd255);
    check("saturate", "no_status", 64'({rx_valid, rx_estop}), 64'd0);

    // Reset in the middle of a frame
    wait_idle("mid_reset");
    slv_reply = {HDR_DATA, 8'h77};
    tx_data = 40'h0F0F0F0F0F;
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    begin
      bit ok = 0;
      for (int i = 0; i < TMO; i++) begin
        @(negedge clk); #1;
        if (slv_bits == 17) begin ok = 1; break; end
      end
      if (!ok) begin
        n_checks++; n_fail++;
        $display("FAIL mid_reset.bit17_timeout: slave bits %0d, expected 17", slv_bits);
      end
    end
    dn_snap = done_cnt;
    rst = 1'b1;
    @(negedge clk); #1;
    check("mid_reset", "ssel",      64'(spi_ssel), 64'd1);
    check("mid_reset", "sck",       64'(spi_sck), 64'd0);
    check("mid_reset", "busy",      64'(busy), 64'd0);
    check("mid_reset", "rx_data",   64'(rx_data), 64'd0);
    check("mid_reset", "err_count", 64'(err_count), 64'd0);
    @(negedge clk); #1;
    rst = 1'b0;
    exp_err = 0;
    repeat (2*FRAME_CYC) @(negedge clk);
    #1;
    check("mid_reset", "no_done", 64'(done_cnt - dn_snap), 64'd0);
    tx_r = 40'h61746164A5;
    rep_r = {HDR_DATA, 8'hA5};
    run_frame("after_reset", tx_r, rep_r);
    check_common("after_reset", tx_r, rep_r);
    check_model("after_reset", rep_r);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
